// File: rtl/tcp_server_ctrl_pkg.sv
// Shared definitions for the passive-open TCP controller: flag masks, connection
// states, pending-control kinds and the outgoing segment record.
package tcp_server_ctrl_pkg;

  localparam logic [5:0] F_FIN = 6'h01;
  localparam logic [5:0] F_SYN = 6'h02;
  localparam logic [5:0] F_RST = 6'h04;
  localparam logic [5:0] F_PSH = 6'h08;
  localparam logic [5:0] F_ACK = 6'h10;
  localparam logic [5:0] F_URG = 6'h20;

  typedef enum logic [2:0] {
    ST_LISTEN     = 3'd0,
    ST_SYN_RCVD   = 3'd1,
    ST_ESTAB      = 3'd2,
    ST_CLOSE_WAIT = 3'd3,
    ST_LAST_ACK   = 3'd4
  } conn_state_e;

  typedef enum logic [1:0] {
    CTL_NONE   = 2'd0,
    CTL_SYNACK = 2'd1,
    CTL_FINACK = 2'd2,
    CTL_ACK    = 2'd3
  } ctl_e;

  typedef struct packed {
    logic [5:0]  flag;
    logic [31:0] seq;
    logic [31:0] ack;
  } tx_seg_t;

endpackage

// File: rtl/tcp_server_ctrl_timer.sv
// Restartable 32-bit up-counter; pulses expire for one cycle when the count reaches
// limit, then stops until restarted. Restart takes priority over clear.
module tcp_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        clear,
  input  logic [31:0] limit,
  output logic        expire
);
  logic [31:0] cnt_q, cnt_d;
  logic        run_q, run_d;

  assign expire = run_q && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (restart) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (clear || expire) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/tcp_server_ctrl.sv
// Passive-open TCP endpoint: LISTEN -> SYN_RCVD -> ESTAB -> CLOSE_WAIT -> LAST_ACK,
// with one registered tx slot toward the encoder and delayed/piggybacked ACKs.
module tcp_server_ctrl
  import tcp_server_ctrl_pkg::*;
#(
  parameter logic [31:0] ISS        = 32'h0000_4000,
  parameter logic [31:0] ACK_DELAY  = 32'd1000000,
  parameter logic [31:0] RTO_CYCLES = 32'd4000000,
  parameter int          MAX_RETX   = 3,
  parameter int          LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_seg_valid,
  input  logic [5:0]       rx_flag,
  input  logic [31:0]      rx_seq,
  input  logic [31:0]      rx_ack,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             app_tx_valid,
  input  logic [LEN_W-1:0] app_tx_len,
  output logic             app_tx_accept,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [5:0]       tx_flag,
  output logic [31:0]      tx_seq,
  output logic [31:0]      tx_ack,
  output logic             rx_deliver,
  output logic [2:0]       conn_state
);
  conn_state_e state_q, state_d;
  ctl_e        ctl_q, ctl_d;
  tx_seg_t     tx_seg_q, tx_seg_d;
  logic [31:0] snd_nxt_q, snd_nxt_d, rcv_nxt_q, rcv_nxt_d;
  logic [7:0]  retx_q, retx_d;
  logic        need_ack_q, need_ack_d, dly_due_q, dly_due_d, tx_valid_q, tx_valid_d;
  logic        dly_restart, dly_clear, dly_exp, rto_restart, rto_clear, rto_exp;
  logic        drop, in_order, slot_free;
  logic        unused_flags;

  assign unused_flags = ^{rx_flag[5], rx_flag[3]};

  tcp_timer u_dly_timer (
    .clk(clk), .rst(rst), .restart(dly_restart), .clear(dly_clear),
    .limit(ACK_DELAY), .expire(dly_exp)
  );

  tcp_timer u_rto_timer (
    .clk(clk), .rst(rst), .restart(rto_restart), .clear(rto_clear),
    .limit(RTO_CYCLES), .expire(rto_exp)
  );

  assign in_order  = (rx_seq == rcv_nxt_q);
  assign slot_free = !tx_valid_q || tx_ready;

  always_comb begin
    state_d       = state_q;
    ctl_d         = ctl_q;
    snd_nxt_d     = snd_nxt_q;
    rcv_nxt_d     = rcv_nxt_q;
    retx_d        = retx_q;
    need_ack_d    = need_ack_q;
    dly_due_d     = dly_due_q;
    tx_valid_d    = tx_valid_q && !tx_ready;
    tx_seg_d      = tx_seg_q;
    rx_deliver    = 1'b0;
    app_tx_accept = 1'b0;
    dly_restart   = 1'b0;
    dly_clear     = 1'b0;
    rto_restart   = 1'b0;
    rto_clear     = 1'b0;
    drop          = 1'b0;

    // Receive side runs first so anything loaded this cycle sees the new rcv_nxt.
    if (rx_seg_valid) begin
      if ((rx_flag & F_RST) != 6'd0 && state_q != ST_LISTEN) begin
        drop = 1'b1;
      end else begin
        case (state_q)
          ST_LISTEN: begin
            if ((rx_flag & F_SYN) != 6'd0 && (rx_flag & F_ACK) == 6'd0) begin
              rcv_nxt_d = rx_seq + 32'd1;
              snd_nxt_d = ISS + 32'd1;
              ctl_d     = CTL_SYNACK;
              retx_d    = '0;
              state_d   = ST_SYN_RCVD;
            end
          end
          ST_SYN_RCVD: begin
            if ((rx_flag & F_ACK) != 6'd0 && rx_ack == snd_nxt_q) begin
              state_d   = ST_ESTAB;
              ctl_d     = CTL_NONE;
              retx_d    = '0;
              rto_clear = 1'b1;
            end else if ((rx_flag & F_SYN) != 6'd0) begin
              ctl_d = CTL_SYNACK;
            end
          end
          ST_ESTAB: begin
            if (in_order && (rx_flag & F_FIN) != 6'd0) begin
              rcv_nxt_d  = rcv_nxt_q + 32'(rx_len) + 32'd1;
              rx_deliver = (rx_len != '0);
              ctl_d      = CTL_ACK;
              state_d    = ST_CLOSE_WAIT;
            end else if (in_order && rx_len != '0) begin
              rcv_nxt_d  = rcv_nxt_q + 32'(rx_len);
              rx_deliver = 1'b1;
              if (need_ack_q) begin
                ctl_d = CTL_ACK;
              end else begin
                need_ack_d  = 1'b1;
                dly_restart = 1'b1;
              end
            end else if (!in_order) begin
              ctl_d = CTL_ACK;
            end
          end
          ST_LAST_ACK: begin
            if ((rx_flag & F_ACK) != 6'd0 && rx_ack == snd_nxt_q) begin
              state_d   = ST_LISTEN;
              snd_nxt_d = ISS;
              ctl_d     = CTL_NONE;
              retx_d    = '0;
              rto_clear = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    if (!drop && rto_exp && (state_d == ST_SYN_RCVD || state_d == ST_LAST_ACK)) begin
      if (retx_q == 8'(MAX_RETX)) begin
        drop = 1'b1;
      end else begin
        ctl_d  = (state_d == ST_SYN_RCVD) ? CTL_SYNACK : CTL_FINACK;
        retx_d = retx_q + 8'd1;
      end
    end

    if (dly_exp && need_ack_q) dly_due_d = 1'b1;

    // Once the ACK for the peer's FIN has been handed to the slot, queue our FIN.
    if (!drop && state_d == ST_CLOSE_WAIT && ctl_d == CTL_NONE) begin
      state_d   = ST_LAST_ACK;
      snd_nxt_d = snd_nxt_d + 32'd1;
      ctl_d     = CTL_FINACK;
      retx_d    = '0;
    end

    if (drop) begin
      state_d     = ST_LISTEN;
      snd_nxt_d   = ISS;
      ctl_d       = CTL_NONE;
      retx_d      = '0;
      need_ack_d  = 1'b0;
      dly_due_d   = 1'b0;
      tx_valid_d  = 1'b0;
      rx_deliver  = 1'b0;
      dly_restart = 1'b0;
      dly_clear   = 1'b1;
      rto_clear   = 1'b1;
    end else if (slot_free) begin
      if (ctl_d != CTL_NONE) begin
        tx_valid_d   = 1'b1;
        tx_seg_d.ack = rcv_nxt_d;
        case (ctl_d)
          CTL_SYNACK: begin
            tx_seg_d.flag = F_SYN | F_ACK;
            tx_seg_d.seq  = ISS;
            rto_restart   = 1'b1;
          end
          CTL_FINACK: begin
            tx_seg_d.flag = F_FIN | F_ACK;
            tx_seg_d.seq  = snd_nxt_d - 32'd1;
            rto_restart   = 1'b1;
          end
          default: begin
            tx_seg_d.flag = F_ACK;
            tx_seg_d.seq  = snd_nxt_d;
          end
        endcase
        ctl_d       = CTL_NONE;
        need_ack_d  = 1'b0;
        dly_due_d   = 1'b0;
        dly_restart = 1'b0;
        dly_clear   = 1'b1;
      end else if (state_d == ST_ESTAB && app_tx_valid) begin
        tx_valid_d    = 1'b1;
        tx_seg_d.flag = F_PSH | F_ACK;
        tx_seg_d.seq  = snd_nxt_d;
        tx_seg_d.ack  = rcv_nxt_d;
        snd_nxt_d     = snd_nxt_d + 32'(app_tx_len);
        app_tx_accept = 1'b1;
        need_ack_d    = 1'b0;
        dly_due_d     = 1'b0;
        dly_restart   = 1'b0;
        dly_clear     = 1'b1;
      end else if (dly_due_d && need_ack_d) begin
        tx_valid_d    = 1'b1;
        tx_seg_d.flag = F_ACK;
        tx_seg_d.seq  = snd_nxt_d;
        tx_seg_d.ack  = rcv_nxt_d;
        need_ack_d    = 1'b0;
        dly_due_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LISTEN;
      ctl_q      <= CTL_NONE;
      snd_nxt_q  <= ISS;
      rcv_nxt_q  <= '0;
      retx_q     <= '0;
      need_ack_q <= 1'b0;
      dly_due_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_seg_q   <= '0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= ctl_d;
      snd_nxt_q  <= snd_nxt_d;
      rcv_nxt_q  <= rcv_nxt_d;
      retx_q     <= retx_d;
      need_ack_q <= need_ack_d;
      dly_due_q  <= dly_due_d;
      tx_valid_q <= tx_valid_d;
      tx_seg_q   <= tx_seg_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_flag    = tx_seg_q.flag;
  assign tx_seq     = tx_seg_q.seq;
  assign tx_ack     = tx_seg_q.ack;
  assign conn_state = state_q;
endmodule
